// File: rtl/multi_timer_ctrl_if.sv
// Command/status bundle for multi_timer_ctrl.
//   master: command decoder side. It drives start/stop/clear/lap/down_mode/load_val and
//           receives count/lap_val/status/count_en/expired.
//   slave:  the timer controller. It has the opposite directions.
// Channel i occupies bits [i*CNT_W +: CNT_W] of load_val, count and lap_val, and
// bits [2i +: 2] of status.
interface multi_timer_ctrl_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH-1:0]       clear;
    logic [NUM_CH-1:0]       lap;
    logic [NUM_CH-1:0]       down_mode;
    logic [NUM_CH*CNT_W-1:0] load_val;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH*CNT_W-1:0] lap_val;
    logic [2*NUM_CH-1:0]     status;
    logic [NUM_CH-1:0]       count_en;
    logic [NUM_CH-1:0]       expired;

    modport master (
        output start, stop, clear, lap, down_mode, load_val,
        input  count, lap_val, status, count_en, expired
    );

    modport slave (
        input  start, stop, clear, lap, down_mode, load_val,
        output count, lap_val, status, count_en, expired
    );
endinterface

// File: rtl/multi_timer_ctrl.sv
// Multi-channel stopwatch/countdown controller.
// Each channel has its own IDLE/RUNNING/PAUSED/EXPIRED FSM and counter. A channel counts up,
// or counts down from load_val and expires at zero. All channels share one free-running
// prescaled tick.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - slave modport of multi_timer_ctrl_if. It carries the per-channel commands
//           start/stop/clear/lap, down_mode and load_val, and returns the registered
//           count, lap_val, status and expired outputs plus count_en, which is decoded
//           from the state.
module multi_timer_ctrl #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input logic               clk,
    input logic               rst_n,
    multi_timer_ctrl_if.slave bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRun     = 2'b01,
        StPause   = 2'b10,
        StExpired = 2'b11
    } state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [CNT_W-1:0]  lap_q   [NUM_CH];
    logic [CNT_W-1:0]  lap_d   [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;       // 1 = countdown
    logic [NUM_CH-1:0] expired_q, expired_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;

    always_comb begin
        tick    = (presc_q == PresLast);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]   = state_q[i];
            count_d[i]   = count_q[i];
            lap_d[i]     = lap_q[i];
            mode_d[i]    = mode_q[i];
            expired_d[i] = 1'b0;

            if (bus.clear[i]) begin
                state_d[i] = StIdle;
                count_d[i] = '0;
                lap_d[i]   = '0;
            end else begin
                // Lap captures the value from before this cycle's update.
                if (bus.lap[i]) begin
                    lap_d[i] = count_q[i];
                end
                case (state_q[i])
                    StIdle, StExpired: begin
                        // stop outranks start, so a simultaneous start is dropped.
                        if (bus.start[i] && !bus.stop[i]) begin
                            mode_d[i] = bus.down_mode[i];
                            if (!bus.down_mode[i]) begin
                                state_d[i] = StRun;
                                count_d[i] = '0;
                            end else if (bus.load_val[i*CNT_W +: CNT_W] == '0) begin
                                state_d[i]   = StExpired;
                                count_d[i]   = '0;
                                expired_d[i] = 1'b1;
                            end else begin
                                state_d[i] = StRun;
                                count_d[i] = bus.load_val[i*CNT_W +: CNT_W];
                            end
                        end
                    end
                    StRun: begin
                        if (bus.stop[i]) begin
                            state_d[i] = StPause;
                        end else if (tick) begin
                            if (!mode_q[i]) begin
                                count_d[i] = count_q[i] + CNT_W'(1);
                            end else if (count_q[i] == CNT_W'(1)) begin
                                count_d[i]   = '0;
                                state_d[i]   = StExpired;
                                expired_d[i] = 1'b1;
                            end else begin
                                count_d[i] = count_q[i] - CNT_W'(1);
                            end
                        end
                    end
                    StPause: begin
                        if (bus.start[i] && !bus.stop[i]) begin
                            state_d[i] = StRun;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        count_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            mode_q    <= '0;
            expired_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                count_q[i] <= '0;
                lap_q[i]   <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                lap_q[i]   <= lap_d[i];
            end
        end
    end

    always_comb begin
        bus.count    = '0;
        bus.lap_val  = '0;
        bus.status   = '0;
        bus.count_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.count[i*CNT_W +: CNT_W]   = count_q[i];
            bus.lap_val[i*CNT_W +: CNT_W] = lap_q[i];
            bus.status[2*i +: 2]          = state_q[i];
            bus.count_en[i]               = (state_q[i] == StRun);
        end
        bus.expired = expired_q;
    end
endmodule

// File: tb/tb_multi_timer_ctrl.sv
// Directed bench for multi_timer_ctrl. It uses three instances:
//   dut  : 4 channels, 16 bit, PRESCALE=1 (main command tests)
//   dut4 : 4 channels, 16 bit, PRESCALE=4 (prescaler tests)
//   dutw : 1 channel,   4 bit, PRESCALE=1 (counter wrap, same behaviour as 0xFFFE->0xFFFF->0)
module tb_multi_timer_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multi_timer_ctrl_if #(.NUM_CH(4), .CNT_W(16)) bus ();
    multi_timer_ctrl_if #(.NUM_CH(4), .CNT_W(16)) bus4 ();
    multi_timer_ctrl_if #(.NUM_CH(1), .CNT_W(4))  busw ();

    multi_timer_ctrl #(.NUM_CH(4), .CNT_W(16), .PRESCALE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multi_timer_ctrl #(.NUM_CH(4), .CNT_W(16), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    multi_timer_ctrl #(.NUM_CH(1), .CNT_W(4), .PRESCALE(1)) dutw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busw)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt(input int ch);
        return bus.count[ch*16 +: 16];
    endfunction

    function automatic logic [15:0] lapv(input int ch);
        return bus.lap_val[ch*16 +: 16];
    endfunction

    function automatic logic [1:0] st(input int ch);
        return bus.status[2*ch +: 2];
    endfunction

    initial begin
        bus.start  = '0; bus.stop  = '0; bus.clear  = '0; bus.lap  = '0;
        bus.down_mode  = '0; bus.load_val  = '0;
        bus4.start = '0; bus4.stop = '0; bus4.clear = '0; bus4.lap = '0;
        bus4.down_mode = '0; bus4.load_val = '0;
        busw.start = '0; busw.stop = '0; busw.clear = '0; busw.lap = '0;
        busw.down_mode = '0; busw.load_val = '0;
        rst_n = 1'b0;
        step();
        step();

        chk("rst_status", 64'(bus.status), 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_lap", 64'(bus.lap_val), 64'h0);
        chk("rst_expired", 64'(bus.expired), 64'h0);
        chk("rst_count_en", 64'(bus.count_en), 64'h0);
        chk("rst_count4", 64'(bus4.count), 64'h0);
        chk("rst_countw", 64'(busw.count), 64'h0);
        rst_n = 1'b1;

        // ch0 stopwatch: start, 10 ticks, pause, resume, 5 ticks.
        bus.start[0] = 1'b1; step(); bus.start[0] = 1'b0;
        chk("ch0_start_cnt", 64'(cnt(0)), 64'd0);
        chk("ch0_count_en", 64'(bus.count_en), 64'b0001);
        repeat (10) step();
        bus.stop[0] = 1'b1; step(); bus.stop[0] = 1'b0;
        chk("ch0_pause_status", 64'(st(0)), 64'b10);
        chk("ch0_pause_cnt", 64'(cnt(0)), 64'd10);
        bus.start[0] = 1'b1; step(); bus.start[0] = 1'b0;
        chk("ch0_resume_status", 64'(st(0)), 64'b01);
        chk("ch0_resume_cnt", 64'(cnt(0)), 64'd10);
        repeat (5) step();
        chk("ch0_cnt15", 64'(cnt(0)), 64'd15);
        bus.stop[0] = 1'b1; step(); bus.stop[0] = 1'b0;
        chk("ch0_hold15", 64'(cnt(0)), 64'd15);

        // ch1 countdown from 3.
        bus.down_mode[1] = 1'b1; bus.load_val[16 +: 16] = 16'd3;
        bus.start[1] = 1'b1; step(); bus.start[1] = 1'b0;
        chk("ch1_load3", 64'(cnt(1)), 64'd3);
        chk("ch1_run_status", 64'(st(1)), 64'b01);
        step();
        chk("ch1_cnt2", 64'(cnt(1)), 64'd2);
        step();
        chk("ch1_cnt1", 64'(cnt(1)), 64'd1);
        chk("ch1_no_exp_yet", 64'(bus.expired), 64'h0);
        step();
        chk("ch1_cnt0", 64'(cnt(1)), 64'd0);
        chk("ch1_exp_status", 64'(st(1)), 64'b11);
        chk("ch1_exp_pulse", 64'(bus.expired), 64'b0010);
        step();
        chk("ch1_exp_low", 64'(bus.expired), 64'h0);
        chk("ch1_exp_hold", 64'(st(1)), 64'b11);
        step();
        chk("ch1_stays0", 64'(cnt(1)), 64'd0);

        // ch2 lap capture at count 5.
        bus.start[2] = 1'b1; step(); bus.start[2] = 1'b0;
        repeat (5) step();
        bus.lap[2] = 1'b1; step(); bus.lap[2] = 1'b0;
        chk("ch2_lap5", 64'(lapv(2)), 64'd5);
        chk("ch2_cnt6", 64'(cnt(2)), 64'd6);
        bus.stop[2] = 1'b1; step(); bus.stop[2] = 1'b0;
        chk("ch2_pause6", 64'(cnt(2)), 64'd6);

        // ch3 simultaneous start+stop+clear+lap while running.
        bus.start[3] = 1'b1; step(); bus.start[3] = 1'b0;
        repeat (3) step();
        bus.lap[3] = 1'b1; step(); bus.lap[3] = 1'b0;
        chk("ch3_lap3", 64'(lapv(3)), 64'd3);
        bus.start[3] = 1'b1; bus.stop[3] = 1'b1; bus.clear[3] = 1'b1; bus.lap[3] = 1'b1;
        step();
        bus.start[3] = 1'b0; bus.stop[3] = 1'b0; bus.clear[3] = 1'b0; bus.lap[3] = 1'b0;
        chk("ch3_clr_status", 64'(st(3)), 64'b00);
        chk("ch3_clr_cnt", 64'(cnt(3)), 64'd0);
        chk("ch3_clr_lap", 64'(lapv(3)), 64'd0);
        chk("ch3_other_cnt0", 64'(cnt(0)), 64'd15);
        chk("ch3_other_st0", 64'(st(0)), 64'b10);
        chk("ch3_other_lap2", 64'(lapv(2)), 64'd5);
        chk("ch3_other_cnt2", 64'(cnt(2)), 64'd6);
        chk("ch3_other_st1", 64'(st(1)), 64'b11);
        chk("ch3_count_en", 64'(bus.count_en), 64'h0);

        // ch1 countdown with load 0, then restart from EXPIRED with load 2.
        bus.clear[1] = 1'b1; step(); bus.clear[1] = 1'b0;
        chk("ch1_clr_idle", 64'(st(1)), 64'b00);
        bus.load_val[16 +: 16] = 16'd0;
        bus.start[1] = 1'b1; step(); bus.start[1] = 1'b0;
        chk("ch1_ld0_status", 64'(st(1)), 64'b11);
        chk("ch1_ld0_pulse", 64'(bus.expired), 64'b0010);
        chk("ch1_ld0_cnt", 64'(cnt(1)), 64'd0);
        step();
        chk("ch1_ld0_pulse_end", 64'(bus.expired), 64'h0);
        bus.load_val[16 +: 16] = 16'd2;
        bus.start[1] = 1'b1; step(); bus.start[1] = 1'b0;
        chk("ch1_re_status", 64'(st(1)), 64'b01);
        chk("ch1_re_cnt2", 64'(cnt(1)), 64'd2);
        step();
        chk("ch1_re_cnt1", 64'(cnt(1)), 64'd1);
        step();
        chk("ch1_re_cnt0", 64'(cnt(1)), 64'd0);
        chk("ch1_re_exp", 64'(bus.expired), 64'b0010);
        chk("ch1_re_status11", 64'(st(1)), 64'b11);

        // PRESCALE=4: 16 running cycles give 4 ticks whatever the prescaler phase.
        bus4.start[0] = 1'b1; step(); bus4.start[0] = 1'b0;
        chk("p4_start_cnt", 64'(bus4.count[15:0]), 64'd0);
        repeat (16) step();
        chk("p4_cnt4", 64'(bus4.count[15:0]), 64'd4);
        chk("p4_status", 64'(bus4.status[1:0]), 64'b01);

        // Wrap at the top of a 4-bit counter.
        busw.start[0] = 1'b1; step(); busw.start[0] = 1'b0;
        repeat (14) step();
        chk("wrap_cnt14", 64'(busw.count), 64'd14);
        step();
        chk("wrap_cnt15", 64'(busw.count), 64'd15);
        step();
        chk("wrap_cnt0", 64'(busw.count), 64'd0);
        chk("wrap_status", 64'(busw.status), 64'b01);

        // Reset mid-run overrides commands.
        bus.start[3] = 1'b1; step(); bus.start[3] = 1'b0;
        step();
        chk("pre_rst_cnt3", 64'(cnt(3)), 64'd1);
        rst_n = 1'b0; bus.start[0] = 1'b1; bus.lap[2] = 1'b1;
        step();
        chk("mid_rst_status", 64'(bus.status), 64'h0);
        chk("mid_rst_count", 64'(bus.count), 64'h0);
        chk("mid_rst_lap", 64'(bus.lap_val), 64'h0);
        chk("mid_rst_expired", 64'(bus.expired), 64'h0);
        chk("mid_rst_count4", 64'(bus4.count), 64'h0);
        chk("mid_rst_status4", 64'(bus4.status), 64'h0);
        rst_n = 1'b1; bus.start[0] = 1'b0; bus.lap[2] = 1'b0;

        // The prescaler restarts at 0, so the first tick comes on the 4th edge after release.
        bus4.start[0] = 1'b1; step(); bus4.start[0] = 1'b0;
        chk("p4_phase_e0", 64'(bus4.count[15:0]), 64'd0);
        step();
        step();
        chk("p4_phase_e2", 64'(bus4.count[15:0]), 64'd0);
        step();
        chk("p4_phase_e3", 64'(bus4.count[15:0]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
